// File: rtl/gb_pkg.sv
// Shared constants and helpers for the Gaussian-blur stencil line buffer.
//   GB_PIX_W / GB_IMG_W / GB_IMG_H / GB_K : default datapath geometry
//   elem_lsb(r, c, k, pix_w)              : bit offset of window element (r, c)
//                                           in the flattened stencil word
package gb_pkg;

   localparam int unsigned GB_PIX_W = 8;
   localparam int unsigned GB_IMG_W = 488;
   localparam int unsigned GB_IMG_H = 648;
   localparam int unsigned GB_K     = 9;

   // r = 0 is the oldest row, c = 0 the oldest column; newest pixel lands on top
   function automatic int unsigned elem_lsb(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned k,
                                            input int unsigned pix_w);
      return (r * k + c) * pix_w;
   endfunction

endpackage

// File: rtl/gb_line_buffer.sv
// One image row of pixel storage.
//   clk     : clock, rising edge
//   we      : write enable
//   addr    : column address, shared by read and write
//   wr_data : pixel written at addr on the clock edge
//   rd_data : pixel currently stored at addr (combinational, pre-write data)
// Contents are intentionally not reset.
module gb_line_buffer
   import gb_pkg::*;
#(
   parameter int unsigned PIX_W = GB_PIX_W,
   parameter int unsigned IMG_W = GB_IMG_W
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(IMG_W)-1:0] addr,
   input  logic [PIX_W-1:0]         wr_data,
   output logic [PIX_W-1:0]         rd_data
);

   logic [PIX_W-1:0] mem_q [IMG_W];

   assign rd_data = mem_q[addr];

   // Synchronous write; same-cycle read returns the old value
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/gb_stencil_linebuf.sv
// Line buffer and KxK stencil generator for the Gaussian-blur datapath.
//   clk, rst            : clock and synchronous active-high reset
//   arg_1_TDATA/TVALID  : raster-order input pixel stream
//   arg_1_TREADY        : input can be accepted (combinational from output state)
//   arg_0_TDATA         : flattened KxK stencil, element (r,c) at elem_lsb(r,c)
//   arg_0_TVALID/TLAST  : stencil valid / final stencil of the frame
//   arg_0_TREADY        : downstream accepts the stencil
// Only window positions fully inside the current frame produce a stencil.
module gb_stencil_linebuf
   import gb_pkg::*;
#(
   parameter int unsigned PIX_W = GB_PIX_W,
   parameter int unsigned IMG_W = GB_IMG_W,
   parameter int unsigned IMG_H = GB_IMG_H,
   parameter int unsigned K     = GB_K
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIX_W-1:0]       arg_1_TDATA,
   input  logic                   arg_1_TVALID,
   output logic                   arg_1_TREADY,
   output logic [K*K*PIX_W-1:0]   arg_0_TDATA,
   output logic                   arg_0_TVALID,
   output logic                   arg_0_TLAST,
   input  logic                   arg_0_TREADY
);

   localparam int unsigned X_W  = $clog2(IMG_W);
   localparam int unsigned Y_W  = $clog2(IMG_H);
   localparam int unsigned ST_W = K * K * PIX_W;
   localparam int unsigned NROW = K - 1;

   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic [PIX_W-1:0] win_q [K][K];
   logic [PIX_W-1:0] win_d [K][K];
   logic [ST_W-1:0]  tdata_q, tdata_d;
   logic             tvalid_q, tvalid_d;
   logic             tlast_q, tlast_d;

   logic [PIX_W-1:0] rd_data [NROW];
   logic [PIX_W-1:0] wr_data [NROW];
   logic [ST_W-1:0]  stencil;
   logic             accept;
   logic             emit;
   logic             last_pix;

   // Output slot is free when empty or being drained this cycle
   assign arg_1_TREADY = !tvalid_q || arg_0_TREADY;
   assign accept       = arg_1_TVALID && arg_1_TREADY;

   assign arg_0_TDATA  = tdata_q;
   assign arg_0_TVALID = tvalid_q;
   assign arg_0_TLAST  = tlast_q;

   // Row memories: on accept every row moves up one slot at this column
   for (genvar j = 0; j < NROW; j++) begin : g_row
      if (j == NROW - 1) begin : g_newest
         assign wr_data[j] = arg_1_TDATA;
      end else begin : g_shift
         assign wr_data[j] = rd_data[j+1];
      end

      gb_line_buffer #(
         .PIX_W (PIX_W),
         .IMG_W (IMG_W)
      ) u_row (
         .clk     (clk),
         .we      (accept),
         .addr    (x_q),
         .wr_data (wr_data[j]),
         .rd_data (rd_data[j])
      );
   end

   // Raster position of the pixel being accepted
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (accept) begin
         if (x_q == X_W'(IMG_W - 1)) begin
            x_d = '0;
            y_d = (y_q == Y_W'(IMG_H - 1)) ? '0 : y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   // Window shifts toward older columns; new column is row reads plus input
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
         end
         for (int unsigned r = 0; r < K - 1; r++) begin
            win_d[r][K-1] = rd_data[r];
         end
         win_d[K-1][K-1] = arg_1_TDATA;
      end
   end

   // Flatten the post-shift window
   always_comb begin
      stencil = '0;
      for (int unsigned r = 0; r < K; r++) begin
         for (int unsigned c = 0; c < K; c++) begin
            stencil[elem_lsb(r, c, K, PIX_W) +: PIX_W] = win_d[r][c];
         end
      end
   end

   assign emit     = accept && (x_q >= X_W'(K - 1)) && (y_q >= Y_W'(K - 1));
   assign last_pix = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));

   // Output register: load on emit, otherwise clear once consumed
   always_comb begin
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;
      if (emit) begin
         tvalid_d = 1'b1;
         tlast_d  = last_pix;
         tdata_d  = stencil;
      end else if (arg_0_TREADY) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
               win_q[r][c] <= win_d[r][c];
            end
         end
      end
   end

endmodule

// File: tb/tb_gb_stencil_linebuf.sv
// Scoreboard bench for gb_stencil_linebuf at 8-bit, 8x6 image, K=3.
module tb_gb_stencil_linebuf;

   localparam int unsigned PW = 8;
   localparam int unsigned IW = 8;
   localparam int unsigned IH = 6;
   localparam int unsigned KK = 3;
   localparam int unsigned SW = KK * KK * PW;
   localparam int unsigned FPIX = IW * IH;

   // First stencil of frame 0: rows {00,01,02} {10,11,12} {20,21,22}
   localparam logic [SW-1:0] FIRST_ST = 72'h222120121110020100;

   typedef struct {
      logic [SW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] arg_1_TDATA;
   logic          arg_1_TVALID;
   logic          arg_1_TREADY;
   logic [SW-1:0] arg_0_TDATA;
   logic          arg_0_TVALID;
   logic          arg_0_TLAST;
   logic          arg_0_TREADY;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   n_out = 0;
   int   n_last = 0;
   logic exp_v;

   always #5 clk = ~clk;

   gb_stencil_linebuf #(
      .PIX_W (PW),
      .IMG_W (IW),
      .IMG_H (IH),
      .K     (KK)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .arg_1_TDATA  (arg_1_TDATA),
      .arg_1_TVALID (arg_1_TVALID),
      .arg_1_TREADY (arg_1_TREADY),
      .arg_0_TDATA  (arg_0_TDATA),
      .arg_0_TVALID (arg_0_TVALID),
      .arg_0_TLAST  (arg_0_TLAST),
      .arg_0_TREADY (arg_0_TREADY)
   );

   function automatic logic [PW-1:0] pix_val(input int f, input int x, input int y);
      return PW'(16 * y + x + 96 * f);
   endfunction

   function automatic logic [SW-1:0] exp_stencil(input int f, input int x, input int y);
      logic [SW-1:0] s;
      s = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            s[(r * 3 + c) * 8 +: 8] = pix_val(f, x - 2 + c, y - 2 + r);
         end
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compare every presented stencil with the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && arg_0_TVALID) begin
            if (sb.size() == 0) begin
               check("spurious_stencil", SW'(arg_0_TVALID), SW'(0));
            end else begin
               check("stencil_data", arg_0_TDATA, sb[0].data);
               check("stencil_last", SW'(arg_0_TLAST), SW'(sb[0].last));
               if (arg_0_TREADY) begin
                  void'(sb.pop_front());
                  n_out++;
                  if (arg_0_TLAST) n_last++;
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      arg_1_TVALID = 1'b0;
      arg_0_TREADY = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sb.delete();
      exp_v = 1'b0;
      #1;
      check("rst_tvalid", SW'(arg_0_TVALID), SW'(0));
      check("rst_tlast",  SW'(arg_0_TLAST),  SW'(0));
      check("rst_tdata",  arg_0_TDATA,       SW'(0));
      check("rst_in_ready", SW'(arg_1_TREADY), SW'(1));
   endtask

   // mode 0: streaming, 1: one 5-cycle stall after the first stencil, 2: random both sides
   task automatic run_phase(input int f0, input int npix, input int mode,
                            input int exp_n, input int exp_last);
      int   p        = 0;
      int   stall    = 0;
      int   guard    = 0;
      int   base_n   = n_out;
      int   base_l   = n_last;
      bit   stalled  = 1'b0;
      bit   acc      = 1'b0;
      bit   acc_prev = 1'b0;
      bit   em;
      int   f, x, y;
      exp_t e;

      while (p < npix && guard < 5000) begin
         @(negedge clk);
         guard++;
         check("tvalid", SW'(arg_0_TVALID), SW'(exp_v));

         if (mode == 2) arg_0_TREADY = ($urandom_range(0, 3) != 0);
         else if (stall > 0) begin
            arg_0_TREADY = 1'b0;
            stall--;
         end else arg_0_TREADY = 1'b1;

         if (acc_prev || !arg_1_TVALID)
            arg_1_TVALID = (mode != 2) || ($urandom_range(0, 3) != 0);
         f = f0 + p / FPIX;
         x = p % IW;
         y = (p / IW) % IH;
         arg_1_TDATA = pix_val(f, x, y);

         #1;
         check("in_ready", SW'(arg_1_TREADY), SW'(!exp_v || arg_0_TREADY));
         acc = arg_1_TVALID && arg_1_TREADY;
         em  = acc && (x >= 2) && (y >= 2);
         if (em) begin
            e.data = (f == 0 && x == 2 && y == 2) ? FIRST_ST : exp_stencil(f, x, y);
            e.last = (x == IW - 1) && (y == IH - 1);
            sb.push_back(e);
            if (mode == 1 && !stalled) begin
               stall   = 5;
               stalled = 1'b1;
            end
         end
         exp_v = acc ? em : (arg_0_TREADY ? 1'b0 : exp_v);
         if (acc) p++;
         acc_prev = acc;
      end
      if (p < npix) check("feed_timeout", SW'(p), SW'(npix));

      guard = 0;
      while ((sb.size() != 0 || exp_v) && guard < 200) begin
         @(negedge clk);
         guard++;
         arg_1_TVALID = 1'b0;
         check("tvalid", SW'(arg_0_TVALID), SW'(exp_v));
         arg_0_TREADY = (mode == 2) ? ($urandom_range(0, 1) != 0) : 1'b1;
         #1;
         exp_v = arg_0_TREADY ? 1'b0 : exp_v;
      end
      @(negedge clk);
      arg_1_TVALID = 1'b0;
      check("drain_left", SW'(sb.size()), SW'(0));
      check("n_stencils", SW'(n_out - base_n), SW'(exp_n));
      check("n_tlast",    SW'(n_last - base_l), SW'(exp_last));
   endtask

   initial begin
      rst          = 1'b1;
      arg_1_TVALID = 1'b0;
      arg_1_TDATA  = '0;
      arg_0_TREADY = 1'b0;
      exp_v        = 1'b0;
      do_reset();

      run_phase(0, FPIX, 0, 24, 1);        // streaming
      run_phase(1, FPIX, 1, 24, 1);        // backpressure
      run_phase(2, 3 * FPIX, 2, 72, 3);    // random handshakes, 3 frames
      run_phase(5, 20, 0, 2, 0);           // partial frame
      do_reset();                          // mid-frame reset
      run_phase(6, FPIX, 0, 24, 1);        // fresh frame after reset

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gb_stencil_linebuf.md
# gb_stencil_linebuf

Parametrised line-buffer and stencil generator for the Gaussian-blur accelerator datapath. It accepts a raster-order pixel stream on an AXI-stream-style input and keeps K-1 full image rows plus a KxK sliding window. Each valid window position produces one flattened KxK stencil on an output stream with full backpressure and an end-of-frame marker. The block sits between the input stream stage and the convolution stage, and generalises the fixed 8-bit, 9x9, 8-row line-buffer design.

## Interface
- PIX_W, 8, pixel width in bits.
- IMG_W, 488, image width in pixels.
- IMG_H, 648, image height in rows.
- K, 9, stencil edge length; legal range 2 ≤ K ≤ min(IMG_W, IMG_H).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- arg_1_TDATA  in  PIX_W  input pixel.
- arg_1_TVALID  in  1  input pixel valid.
- arg_1_TREADY  out  1  block can accept a pixel.
- arg_0_TDATA  out  K*K*PIX_W  flattened stencil.
- arg_0_TVALID  out  1  stencil valid.
- arg_0_TLAST  out  1  marks the final stencil of a frame.
- arg_0_TREADY  in  1  downstream accepts the stencil.

## Operation
- Accept: a pixel is accepted on a cycle where arg_1_TVALID & arg_1_TREADY are both high.
- Ready: arg_1_TREADY = !arg_0_TVALID | arg_0_TREADY, combinational.
- Position counters: x (width $clog2(IMG_W)) and y (width $clog2(IMG_H)) give the position of the accepted pixel.
  - x increments per accept and wraps IMG_W-1 → 0.
  - On an x wrap, y increments; y wraps IMG_H-1 → 0, which starts a new frame.
- Line buffers: K-1 row memories, each IMG_W x PIX_W.
  - On accept at column x, read all K-1 rows at x, combinationally, old data.
  - Write the rows shifted up: row j ← row j+1, and the newest row ← the input pixel.
- Window: KxK register array. On accept, all columns shift one position toward older.
  - The new column is {row0..row(K-2) read values, input pixel}, oldest row first.
- Packing: element (r, c), with r = 0 the oldest row and c = 0 the oldest column, occupies arg_0_TDATA[(r*K+c)*PIX_W +: PIX_W].
  - The newest pixel is in the top PIX_W bits.
- Emission: a stencil is emitted only when the accepted pixel has x ≥ K-1 and y ≥ K-1 (valid-region mode, no border padding).
  - This gives (IMG_W-K+1)*(IMG_H-K+1) stencils per frame.
- TLAST is 1 only on the stencil from pixel (IMG_W-1, IMG_H-1).
- Rows are not flushed between frames. Stale row and window data is never emitted, because the emission conditions require a full window from the current frame.
- The line-buffer memories are not reset.

## Timing
- Reset values: arg_0_TVALID=0, arg_0_TLAST=0, arg_0_TDATA=0, x=0, y=0, window=0.
  - arg_1_TREADY is therefore 1 on the first cycle after reset.
- Reset asserted mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
- Latency: a stencil appears on arg_0 one cycle after the accept of its final pixel. Output is registered.
- Output hold: while arg_0_TVALID=1 and arg_0_TREADY=0, TDATA and TLAST stay stable and no input is accepted.
- Simultaneous events, on a cycle where the output handshake completes and an input is accepted:
  - If the new pixel emits, the output register loads the new stencil and TVALID stays 1.
  - Otherwise TVALID goes to 0.
- If the output handshake completes with no accept, TVALID goes to 0.
- Sustained throughput is one pixel per cycle when arg_0_TREADY=1.
- There is no combinational path from arg_1_TVALID or arg_1_TDATA to any output.

## Structure
- Package gb_pkg holds:
  - default constants GB_PIX_W=8, GB_IMG_W=488, GB_IMG_H=648, GB_K=9;
  - a function elem_lsb(r, c, K, PIX_W) giving the packing offset.
- Sub-module gb_line_buffer: one IMG_W x PIX_W row memory with combinational read and synchronous write, instantiated K-1 times.
- The top level holds the counters, window array and output register.

## Test plan
All scenarios use PIX_W=8, IMG_W=8, IMG_H=6, K=3, and pixel value = 16*y + x, unless stated otherwise.
- Streaming, ready always 1: feed 48 pixels → 24 stencils.
  - First stencil appears the cycle after pixel 18 (x=2, y=2), with elements r0:{00,01,02} r1:{10,11,12} r2:{20,21,22}.
  - TLAST only on the stencil whose newest element is 0x57.
- Backpressure: hold arg_0_TREADY=0 for 5 cycles after the first stencil.
  - TDATA stays stable and arg_1_TREADY=0 throughout.
  - After release, the stencil sequence is unchanged and no pixel is lost.
- Random TVALID/TREADY toggling on both sides over 3 back-to-back frames.
  - Result: 72 stencils, matching the reference-model sequence.
  - TLAST appears exactly 3 times, and the frame 2 data is not corrupted by frame 1 rows.
- Mid-frame reset after 20 pixels, then a full frame.
  - The first stencil again comes from pixel (2,2) of the new frame.
  - No stencil is emitted from the pre-reset data.
- Row boundary: check that the stencils from pixels (7,2) and (2,3) are consecutive.
  - Pixels (0,3) and (1,3) emit nothing.
- Default parameters (488x648, K=9): one frame → 480*640 = 307200 stencils.
  - The last stencil's top byte equals the final pixel value.
